// File: rtl/ctrl_port_arbiter.sv
// SNES controller port arbiter: routes one console port to one of four device
// serializers, applies device switches only between reads and blanks the port afterwards.
module ctrl_port_arbiter #(
  parameter int unsigned DEV_INIT      = 1,
  parameter int unsigned BLANK_LATCHES = 2,
  parameter int unsigned IDLE_TIMEOUT  = 4096
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] DEV_SEL,
  input  logic       PORT_LATCH,
  input  logic       PORT_CLK,
  input  logic [7:0] DEV_DO,
  input  logic [3:0] DEV_P6,
  output logic [1:0] PORT_DO,
  output logic       PORT_P6,
  output logic [3:0] DEV_LATCH,
  output logic [3:0] DEV_CLK,
  output logic [1:0] ACTIVE_DEV,
  output logic       SWITCHING,
  output logic       GUN_EN,
  output logic       GUN_TYPE,
  output logic [5:0] READ_BITS
);

  localparam int unsigned TO_W = 13;
  localparam int unsigned BC_W = 4;
  localparam int unsigned RB_W = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_BLANK = 2'd3;

  localparam logic [1:0]      ACT_INIT  = 2'(DEV_INIT);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(IDLE_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX    = {TO_W{1'b1}};
  localparam logic [BC_W-1:0] BLANK_LD  = BC_W'(BLANK_LATCHES);
  localparam logic [RB_W-1:0] RB_MAX    = {RB_W{1'b1}};

  logic [1:0]      r_state, w_state_nxt;
  logic [1:0]      r_active, w_active_nxt;
  logic            r_pending, w_pending_nxt;
  logic [BC_W-1:0] r_blank_cnt, w_blank_nxt;
  logic [TO_W-1:0] r_timeout, w_timeout_nxt;
  logic [RB_W-1:0] r_read_bits, w_read_bits_nxt;

  logic r_latch_q, r_latch_qq;
  logic r_clk_q, r_clk_qq;

  logic            w_latch_rise, w_latch_fall, w_clk_rise;
  logic            w_route;
  logic [3:0]      w_onehot;
  logic [RB_W-1:0] w_read_bits_inc;

  assign w_latch_rise    = r_latch_q & ~r_latch_qq;
  assign w_latch_fall    = ~r_latch_q & r_latch_qq;
  assign w_clk_rise      = r_clk_q & ~r_clk_qq;
  assign w_read_bits_inc = (r_read_bits == RB_MAX) ? r_read_bits : r_read_bits + RB_W'(1);

  // Pin synchronisation and edge history
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_latch_q  <= 1'b0;
      r_latch_qq <= 1'b0;
      r_clk_q    <= 1'b0;
      r_clk_qq   <= 1'b0;
    end else begin
      r_latch_q  <= PORT_LATCH;
      r_latch_qq <= r_latch_q;
      r_clk_q    <= PORT_CLK;
      r_clk_qq   <= r_clk_q;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_active    <= ACT_INIT;
      r_pending   <= 1'b0;
      r_blank_cnt <= '0;
      r_timeout   <= '0;
      r_read_bits <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_pending   <= w_pending_nxt;
      r_blank_cnt <= w_blank_nxt;
      r_timeout   <= w_timeout_nxt;
      r_read_bits <= w_read_bits_nxt;
    end
  end

  // Next-state logic; a pending switch is only taken from IDLE so reads are never cut
  always_comb begin
    w_state_nxt     = r_state;
    w_active_nxt    = r_active;
    w_pending_nxt   = (DEV_SEL != r_active);
    w_blank_nxt     = r_blank_cnt;
    w_timeout_nxt   = r_timeout;
    w_read_bits_nxt = r_read_bits;

    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_active_nxt  = DEV_SEL;
          w_pending_nxt = 1'b0;
          w_blank_nxt   = BLANK_LD;
          w_state_nxt   = S_BLANK;
        end else if (w_latch_rise) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        if (w_latch_fall) begin
          w_state_nxt     = S_SHIFT;
          w_read_bits_nxt = '0;
          w_timeout_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (w_latch_rise) begin
          w_state_nxt = S_LATCH;
        end else if (w_clk_rise) begin
          w_read_bits_nxt = w_read_bits_inc;
          w_timeout_nxt   = '0;
        end else if (r_timeout == TO_LAST) begin
          w_state_nxt = S_IDLE;
        end else if (r_timeout != TO_MAX) begin
          w_timeout_nxt = r_timeout + TO_W'(1);
        end
      end
      default: begin
        if (w_latch_fall) begin
          w_read_bits_nxt = '0;
          if (r_blank_cnt <= BC_W'(1)) begin
            w_blank_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_blank_nxt = r_blank_cnt - BC_W'(1);
          end
        end else if (w_clk_rise) begin
          w_read_bits_nxt = w_read_bits_inc;
        end
      end
    endcase
  end

  // Routing follows the next state so a switch never leaks a latch to the old device
  assign w_route  = (w_state_nxt != S_BLANK) && (w_active_nxt != 2'd0);
  assign w_onehot = 4'd1 << w_active_nxt;

  // Registered port outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PORT_DO   <= 2'b00;
      PORT_P6   <= 1'b1;
      DEV_LATCH <= 4'd0;
      DEV_CLK   <= 4'd0;
      SWITCHING <= 1'b0;
      GUN_EN    <= (ACT_INIT == 2'd2) || (ACT_INIT == 2'd3);
      GUN_TYPE  <= (ACT_INIT == 2'd3);
    end else begin
      if (w_route) begin
        PORT_DO   <= DEV_DO[{w_active_nxt, 1'b0} +: 2];
        PORT_P6   <= DEV_P6[w_active_nxt];
        DEV_LATCH <= w_onehot & {4{r_latch_q}};
        DEV_CLK   <= w_onehot & {4{r_clk_q}};
      end else begin
        PORT_DO   <= 2'b00;
        PORT_P6   <= 1'b1;
        DEV_LATCH <= 4'd0;
        DEV_CLK   <= 4'd0;
      end
      SWITCHING <= w_pending_nxt | (w_state_nxt == S_BLANK);
      GUN_EN    <= ((w_active_nxt == 2'd2) || (w_active_nxt == 2'd3)) && (w_state_nxt != S_BLANK);
      GUN_TYPE  <= (w_active_nxt == 2'd3);
    end
  end

  assign ACTIVE_DEV = r_active;
  assign READ_BITS  = r_read_bits;

endmodule

// File: tb/tb_ctrl_port_arbiter.sv
// Bench for ctrl_port_arbiter: scenario tasks with randomized data checked
// against a transaction-level model of the active device and read counts.
module tb_ctrl_port_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] DEV_SEL = 2'd1;
  logic       PORT_LATCH = 1'b0;
  logic       PORT_CLK = 1'b0;
  logic [7:0] DEV_DO = 8'd0;
  logic [3:0] DEV_P6 = 4'hF;
  logic [1:0] PORT_DO;
  logic       PORT_P6;
  logic [3:0] DEV_LATCH;
  logic [3:0] DEV_CLK;
  logic [1:0] ACTIVE_DEV;
  logic       SWITCHING;
  logic       GUN_EN;
  logic       GUN_TYPE;
  logic [5:0] READ_BITS;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] m_active = 2'd1;

  ctrl_port_arbiter #(.DEV_INIT(1), .BLANK_LATCHES(2), .IDLE_TIMEOUT(4096)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DEV_SEL(DEV_SEL), .PORT_LATCH(PORT_LATCH),
    .PORT_CLK(PORT_CLK), .DEV_DO(DEV_DO), .DEV_P6(DEV_P6), .PORT_DO(PORT_DO),
    .PORT_P6(PORT_P6), .DEV_LATCH(DEV_LATCH), .DEV_CLK(DEV_CLK),
    .ACTIVE_DEV(ACTIVE_DEV), .SWITCHING(SWITCHING), .GUN_EN(GUN_EN),
    .GUN_TYPE(GUN_TYPE), .READ_BITS(READ_BITS)
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] exp_do(input logic [1:0] a, input logic [7:0] d);
    if (a == 2'd0) return 2'b00;
    return d[2*a +: 2];
  endfunction

  function automatic logic exp_p6(input logic [1:0] a, input logic [3:0] p);
    if (a == 2'd0) return 1'b1;
    return p[a];
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] a);
    if (a == 2'd0) return 4'd0;
    return 4'd1 << a;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic latch_pulse();
    PORT_LATCH = 1'b1; tick(2);
    PORT_LATCH = 1'b0; tick(2);
  endtask

  task automatic clk_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      PORT_CLK = 1'b1; tick(2);
      PORT_CLK = 1'b0; tick(2);
    end
  endtask

  task automatic test_reset();
    tick(2);
    n_checks++; if (PORT_DO !== 2'b00) begin n_errors++; $display("FAIL reset_port_do got %b want 00", PORT_DO); end
    n_checks++; if (PORT_P6 !== 1'b1) begin n_errors++; $display("FAIL reset_port_p6 got %b want 1", PORT_P6); end
    n_checks++; if ({DEV_LATCH, DEV_CLK} !== 8'd0) begin n_errors++; $display("FAIL reset_dev_gates got %b want 0", {DEV_LATCH, DEV_CLK}); end
    n_checks++; if (ACTIVE_DEV !== 2'd1) begin n_errors++; $display("FAIL reset_active got %0d want 1", ACTIVE_DEV); end
    n_checks++; if ({SWITCHING, GUN_EN, GUN_TYPE} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got %b want 000", {SWITCHING, GUN_EN, GUN_TYPE}); end
    n_checks++; if (READ_BITS !== 6'd0) begin n_errors++; $display("FAIL reset_read_bits got %0d want 0", READ_BITS); end
    RESET_N = 1'b1;
    tick(2);
  endtask

  task automatic test_gamepad_read();
    int n;
    logic [7:0] d;
    DEV_DO = 8'b00_00_10_00;
    PORT_LATCH = 1'b1;
    tick(1);
    n_checks++; if (DEV_LATCH !== 4'd0) begin n_errors++; $display("FAIL latch_latency got %b want 0000", DEV_LATCH); end
    tick(1);
    n_checks++; if (DEV_LATCH !== 4'b0010) begin n_errors++; $display("FAIL latch_route got %b want 0010", DEV_LATCH); end
    n_checks++; if (PORT_DO !== 2'b10) begin n_errors++; $display("FAIL gamepad_do got %b want 10", PORT_DO); end
    PORT_LATCH = 1'b0; tick(2);
    for (int k = 0; k < 16; k++) begin
      PORT_CLK = 1'b1; tick(2);
      n_checks++; if (DEV_CLK !== 4'b0010) begin n_errors++; $display("FAIL clk_route[%0d] got %b want 0010", k, DEV_CLK); end
      PORT_CLK = 1'b0; tick(2);
    end
    n_checks++; if (READ_BITS !== 6'd16) begin n_errors++; $display("FAIL read_bits_16 got %0d want 16", READ_BITS); end
    for (int it = 0; it < 6; it++) begin
      d = 8'($urandom);
      n = $urandom_range(1, 70);
      DEV_DO = d;
      latch_pulse();
      clk_pulses(n);
      n_checks++; if (READ_BITS !== 6'((n > 63) ? 63 : n)) begin n_errors++; $display("FAIL rand_read_bits n=%0d got %0d", n, READ_BITS); end
      n_checks++; if (PORT_DO !== exp_do(m_active, d)) begin n_errors++; $display("FAIL rand_port_do got %b want %b", PORT_DO, exp_do(m_active, d)); end
    end
  endtask

  task automatic test_cancel();
    latch_pulse();
    clk_pulses(3);
    DEV_SEL = 2'd3; tick(2);
    n_checks++; if (SWITCHING !== 1'b1) begin n_errors++; $display("FAIL cancel_pending got %b want 1", SWITCHING); end
    DEV_SEL = m_active; tick(2);
    n_checks++; if (SWITCHING !== 1'b0) begin n_errors++; $display("FAIL cancel_cleared got %b want 0", SWITCHING); end
    clk_pulses(2);
    PORT_LATCH = 1'b1; tick(2);
    n_checks++; if (DEV_LATCH !== onehot(m_active)) begin n_errors++; $display("FAIL cancel_no_blank got %b want %b", DEV_LATCH, onehot(m_active)); end
    PORT_LATCH = 1'b0; tick(2);
    n_checks++; if (ACTIVE_DEV !== m_active) begin n_errors++; $display("FAIL cancel_active got %0d want %0d", ACTIVE_DEV, m_active); end
  endtask

  task automatic test_simultaneous();
    latch_pulse();
    clk_pulses(7);
    n_checks++; if (READ_BITS !== 6'd7) begin n_errors++; $display("FAIL simul_pre got %0d want 7", READ_BITS); end
    PORT_LATCH = 1'b1; PORT_CLK = 1'b1; tick(2);
    n_checks++; if (READ_BITS !== 6'd7) begin n_errors++; $display("FAIL simul_no_incr got %0d want 7", READ_BITS); end
    n_checks++; if (DEV_LATCH !== onehot(m_active)) begin n_errors++; $display("FAIL simul_latch got %b want %b", DEV_LATCH, onehot(m_active)); end
    PORT_LATCH = 1'b0; PORT_CLK = 1'b0; tick(2);
    n_checks++; if (READ_BITS !== 6'd0) begin n_errors++; $display("FAIL simul_cleared got %0d want 0", READ_BITS); end
    clk_pulses(1);
    n_checks++; if (READ_BITS !== 6'd1) begin n_errors++; $display("FAIL simul_shift got %0d want 1", READ_BITS); end
  endtask

  task automatic test_switch_timeout();
    DEV_DO = 8'b00_11_01_00;
    DEV_P6 = 4'b1011;
    latch_pulse();
    clk_pulses(5);
    DEV_SEL = 2'd2; tick(2);
    n_checks++; if (SWITCHING !== 1'b1) begin n_errors++; $display("FAIL sw_pending got %b want 1", SWITCHING); end
    tick(4000);
    n_checks++; if (ACTIVE_DEV !== 2'd1) begin n_errors++; $display("FAIL sw_early got %0d want 1", ACTIVE_DEV); end
    tick(200);
    n_checks++; if (ACTIVE_DEV !== 2'd2) begin n_errors++; $display("FAIL sw_applied got %0d want 2", ACTIVE_DEV); end
    n_checks++; if ({SWITCHING, GUN_EN} !== 2'b10) begin n_errors++; $display("FAIL sw_blank_flags got %b want 10", {SWITCHING, GUN_EN}); end
    for (int b = 0; b < 2; b++) begin
      PORT_LATCH = 1'b1; tick(2);
      n_checks++; if ({DEV_LATCH, PORT_DO, PORT_P6} !== 7'b0000_00_1) begin n_errors++; $display("FAIL blank_out[%0d] got %b want 0000001", b, {DEV_LATCH, PORT_DO, PORT_P6}); end
      PORT_LATCH = 1'b0; tick(2);
    end
    m_active = 2'd2;
    n_checks++; if ({SWITCHING, GUN_EN, GUN_TYPE} !== 3'b010) begin n_errors++; $display("FAIL post_blank_flags got %b want 010", {SWITCHING, GUN_EN, GUN_TYPE}); end
    PORT_LATCH = 1'b1; tick(2);
    n_checks++; if (DEV_LATCH !== 4'b0100) begin n_errors++; $display("FAIL third_latch got %b want 0100", DEV_LATCH); end
    n_checks++; if ({PORT_DO, PORT_P6} !== {exp_do(m_active, DEV_DO), exp_p6(m_active, DEV_P6)}) begin n_errors++; $display("FAIL dev2_return got %b want 110", {PORT_DO, PORT_P6}); end
    PORT_LATCH = 1'b0; tick(2);
  endtask

  task automatic do_switch(input logic [1:0] nd);
    DEV_SEL = nd;
    tick(4200);
    n_checks++; if ({ACTIVE_DEV, SWITCHING} !== {nd, 1'b1}) begin n_errors++; $display("FAIL do_switch_blank got %b want %b", {ACTIVE_DEV, SWITCHING}, {nd, 1'b1}); end
    latch_pulse();
    latch_pulse();
    m_active = nd;
    n_checks++; if (SWITCHING !== 1'b0) begin n_errors++; $display("FAIL do_switch_done got %b want 0", SWITCHING); end
  endtask

  task automatic test_p6();
    do_switch(2'd3);
    n_checks++; if ({GUN_EN, GUN_TYPE} !== 2'b11) begin n_errors++; $display("FAIL justifier_flags got %b want 11", {GUN_EN, GUN_TYPE}); end
    for (int it = 0; it < 8; it++) begin
      DEV_P6 = 4'($urandom);
      DEV_DO = 8'($urandom);
      tick(1);
      n_checks++; if ({PORT_DO, PORT_P6} !== {exp_do(m_active, DEV_DO), exp_p6(m_active, DEV_P6)}) begin n_errors++; $display("FAIL p6_follow got %b want %b", {PORT_DO, PORT_P6}, {exp_do(m_active, DEV_DO), exp_p6(m_active, DEV_P6)}); end
    end
    do_switch(2'd0);
    n_checks++; if ({GUN_EN, GUN_TYPE} !== 2'b00) begin n_errors++; $display("FAIL none_flags got %b want 00", {GUN_EN, GUN_TYPE}); end
    for (int it = 0; it < 6; it++) begin
      DEV_P6 = 4'($urandom);
      DEV_DO = 8'($urandom);
      PORT_LATCH = it[0];
      tick(2);
      n_checks++; if ({DEV_LATCH, PORT_DO, PORT_P6} !== {onehot(m_active), exp_do(m_active, DEV_DO), exp_p6(m_active, DEV_P6)}) begin n_errors++; $display("FAIL none_out got %b want 0000001", {DEV_LATCH, PORT_DO, PORT_P6}); end
    end
    PORT_LATCH = 1'b0; tick(2);
  endtask

  task automatic test_reset_in_blank();
    DEV_SEL = 2'd2;
    tick(4200);
    latch_pulse();
    clk_pulses(40);
    n_checks++; if ({READ_BITS, SWITCHING} !== {6'd40, 1'b1}) begin n_errors++; $display("FAIL blank_count got %0d/%b want 40/1", READ_BITS, SWITCHING); end
    PORT_LATCH = 1'b1;
    tick(2);
    RESET_N = 1'b0;
    #1;
    n_checks++; if ({READ_BITS, ACTIVE_DEV} !== {6'd0, 2'd1}) begin n_errors++; $display("FAIL async_rst_state got %0d/%0d want 0/1", READ_BITS, ACTIVE_DEV); end
    n_checks++; if ({SWITCHING, GUN_EN, GUN_TYPE, PORT_DO, PORT_P6} !== 6'b000_00_1) begin n_errors++; $display("FAIL async_rst_out got %b want 000001", {SWITCHING, GUN_EN, GUN_TYPE, PORT_DO, PORT_P6}); end
    n_checks++; if ({DEV_LATCH, DEV_CLK} !== 8'd0) begin n_errors++; $display("FAIL async_rst_gates got %b want 0", {DEV_LATCH, DEV_CLK}); end
    PORT_LATCH = 1'b0;
    DEV_SEL = 2'd1;
    m_active = 2'd1;
    tick(2);
    RESET_N = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_gamepad_read();
    test_cancel();
    test_simultaneous();
    test_switch_timeout();
    test_p6();
    test_reset_in_blank();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
